// File: rtl/seq_generator.sv
// rtl/seq_generator.sv - programmable MSB-first serial pattern transmitter
module seq_generator #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int RPT_W   = 4,
    parameter int GAP_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [RPT_W-1:0]   rpt,
    input  logic [GAP_W-1:0]   gap,
    output logic               x,
    output logic               x_valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    localparam logic [LEN_W:0] MAX_LEN_E = (LEN_W+1)'(MAX_LEN);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] frame_q, frame_d;
    logic [MAX_LEN-1:0] shift_q, shift_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [RPT_W-1:0]   frames_q, frames_d;
    logic [GAP_W-1:0]   gap_len_q, gap_len_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               x_q, x_d;
    logic               x_valid_q, x_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               len_ok;
    logic [LEN_W:0]     shamt;

    always_comb begin
        len_ok = (len != '0) && ({1'b0, len} <= MAX_LEN_E);
        shamt  = MAX_LEN_E - {1'b0, len};
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        shift_d   = shift_q;
        len_d     = len_q;
        bit_cnt_d = bit_cnt_q;
        frames_d  = frames_q;
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        // Left-justify so the first bit always sits in the MSB of the shifter.
                        frame_d   = pattern << shamt;
                        shift_d   = pattern << shamt;
                        len_d     = len;
                        bit_cnt_d = len - LEN_W'(1);
                        frames_d  = rpt;
                        gap_len_d = gap;
                        state_d   = S_SEND;
                        x_valid_d = 1'b1;
                        busy_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SEND: begin
                busy_d = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - LEN_W'(1);
                    shift_d   = shift_q << 1;
                    x_valid_d = 1'b1;
                end else if (frames_q != '0) begin
                    frames_d = frames_q - RPT_W'(1);
                    if (gap_len_q != '0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = gap_len_q;
                    end else begin
                        shift_d   = frame_q;
                        bit_cnt_d = len_q - LEN_W'(1);
                        x_valid_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_GAP: begin
                busy_d = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d   = S_SEND;
                    shift_d   = frame_q;
                    bit_cnt_d = len_q - LEN_W'(1);
                    x_valid_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        x_d = x_valid_d & shift_d[MAX_LEN-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            shift_q   <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            frames_q  <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            shift_q   <= shift_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            frames_q  <= frames_d;
            gap_len_q <= gap_len_d;
            gap_cnt_q <= gap_cnt_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_seq_generator.sv
// tb/tb_seq_generator.sv - scoreboard bench for seq_generator with a frame-level reference model
module tb_seq_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic [3:0]  rpt;
    logic [3:0]  gap;
    logic        x, x_valid, busy, done, err;

    int checks = 0;
    int errors = 0;

    // Each entry is the expected {x, x_valid, busy, done, err} for one non-quiet output cycle.
    logic [4:0] sb[$];

    seq_generator #(.MAX_LEN(16), .LEN_W(5), .RPT_W(4), .GAP_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pattern(pattern), .len(len), .rpt(rpt), .gap(gap),
        .x(x), .x_valid(x_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [4:0] act;
        logic [4:0] exp_v;
        act = {x, x_valid, busy, done, err};
        if (act != 5'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output act=%b exp=none t=%0t", act, $time);
            end else begin
                exp_v = sb.pop_front();
                if (act !== exp_v) begin
                    errors++;
                    $display("FAIL stream act=%b exp=%b t=%0t", act, exp_v, $time);
                end
            end
        end
    end

    task automatic check_quiet(input string name);
        checks++;
        if ({x, x_valid, busy, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL %s act=%b exp=00000", name, {x, x_valid, busy, done, err});
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drained act=%0d exp=0", sb.size());
        end
    endtask

    // cut_kind: 0 none, 1 abort, 2 reset; cut_at <= 0 picks a random cut point.
    task automatic send(input logic [15:0] p, input int l, input int r, input int g,
                        input int cut_kind, input int cut_at, input bit noise);
        logic [4:0] loc[$];
        int total;
        int cut;
        @(negedge clk);
        pattern = p;
        len     = l[4:0];
        rpt     = r[3:0];
        gap     = g[3:0];
        start   = 1'b1;
        if (l == 0 || l > 16) begin
            sb.push_back(5'b00001);
            @(posedge clk);
            #1 start = 1'b0;
            return;
        end
        for (int f = 0; f <= r; f++) begin
            for (int i = l - 1; i >= 0; i--) loc.push_back({p[i], 1'b1, 1'b1, 2'b00});
            if (f < r) for (int k = 0; k < g; k++) loc.push_back(5'b00100);
        end
        total = loc.size();
        loc.push_back(5'b00010);
        cut = 0;
        if (cut_kind != 0 && total > 1)
            cut = (cut_at > 0 && cut_at < total) ? cut_at : $urandom_range(1, total - 1);
        if (cut == 0) foreach (loc[i]) sb.push_back(loc[i]);
        else for (int i = 0; i < cut; i++) sb.push_back(loc[i]);
        @(posedge clk);
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            if (cut != 0 && c == cut) begin
                start = 1'b0;
                if (cut_kind == 1) abort = 1'b1;
                else reset = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
                reset = 1'b0;
                if (cut_kind == 2) check_quiet("reset_mid_frame");
                return;
            end
            if (noise && c < total) begin
                start   = 1'($urandom_range(0, 1));
                pattern = 16'($urandom);
                len     = 5'($urandom_range(0, 31));
                rpt     = 4'($urandom_range(0, 15));
                gap     = 4'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        len     = '0;
        rpt     = '0;
        gap     = '0;
        repeat (3) @(posedge clk);
        #1 check_quiet("reset_state");
        reset = 1'b0;

        send(16'h0009, 4, 0, 0, 0, 0, 0);
        send(16'h0009, 4, 2, 0, 0, 0, 0);
        send(16'h0009, 4, 1, 2, 0, 0, 0);
        idle_check(3);
        send(16'h0009, 0, 0, 0, 0, 0, 0);
        send(16'h0009, 17, 0, 0, 0, 0, 0);
        idle_check(3);
        send(16'h0009, 4, 0, 0, 0, 0, 1);
        send(16'h0009, 4, 2, 0, 1, 6, 0);
        idle_check(3);
        send(16'h0009, 4, 0, 0, 2, 2, 0);
        send(16'h0001, 1, 0, 0, 0, 0, 0);
        idle_check(3);
        send(16'hA5C3, 16, 15, 1, 0, 0, 1);
        send(16'hFFFF, 1, 3, 0, 0, 0, 0);
        send(16'h0002, 2, 2, 3, 1, 7, 0);
        idle_check(3);

        for (int t = 0; t < 40; t++) begin
            int l, kind, ck;
            if ($urandom_range(0, 7) == 0) l = $urandom_range(0, 1) ? 0 : $urandom_range(17, 31);
            else l = $urandom_range(1, 16);
            kind = $urandom_range(0, 5);
            ck = (kind == 0) ? 1 : (kind == 1) ? 2 : 0;
            send(16'($urandom), l, $urandom_range(0, 15), $urandom_range(0, 15), ck, 0,
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_check($urandom_range(1, 4));
        end
        idle_check(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
